tx_frame_src: RTL and testbench

Upstream feeder for `tx_dwidth_conv`. It accepts payload beats on an AXI4-Stream slave and buffers them in a 2-entry queue. It builds one `DWIDTH_IN`-bit frame per frame period, with a 2-bit header, and fills empty or paused slots with IDLE frames. It also owns the free-running `clk_cnt` frame-phase counter that `tx_dwidth_conv` uses to serialise each frame onto the `DWIDTH_OUT`-bit lane.

---
 rtl/tx_frame_src.sv | 110 +++++++++++
 tb/tb_tx_frame_src.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_src.sv
// tx_frame_src: frame source feeding tx_dwidth_conv.
// Buffers AXI4-Stream payload beats in a 2-entry queue and emits one
// DWIDTH_IN-bit frame per frame period (RATIO = DWIDTH_IN/DWIDTH_OUT cycles).
// A frame is DATA {2'b01, payload} or IDLE {2'b10, 8'h1E, 0...}. It also owns
// the free-running frame-phase counter clk_cnt.
// Optional feature macro: TX_FRAME_SRC_STATS_EN adds the data_frame_cnt and
// idle_frame_cnt frame counters.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_axis_tdata/tvalid payload beat in (DWIDTH_IN-2 bits)
//   s_axis_tready       queue not full (registered)
//   pause               send IDLE instead of data (sampled at boundaries)
//   clk_cnt             frame phase 0..RATIO-1
//   din                 current frame
//   data_frame_cnt      DATA frames loaded (TX_FRAME_SRC_STATS_EN only)
//   idle_frame_cnt      IDLE frames loaded (TX_FRAME_SRC_STATS_EN only)
module tx_frame_src #(
  parameter int unsigned DWIDTH_IN  = 256,
  parameter int unsigned DWIDTH_OUT = 64,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DWIDTH_IN-3:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   pause,
  output logic [CNT_WIDTH-1:0]   clk_cnt,
  output logic [DWIDTH_IN-1:0]   din
`ifdef TX_FRAME_SRC_STATS_EN
  ,
  output logic [31:0]            data_frame_cnt,
  output logic [31:0]            idle_frame_cnt
`endif
);

  localparam int unsigned PAY_W = DWIDTH_IN - 2;
  localparam int unsigned RATIO = DWIDTH_IN / DWIDTH_OUT;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);
  localparam logic [DWIDTH_IN-1:0] IDLE_FRAME =
    {2'b10, 8'h1E, {(DWIDTH_IN-10){1'b0}}};

  logic [PAY_W-1:0] q0;
  logic [PAY_W-1:0] q1;
  logic [1:0]       occ;

  logic             boundary_c;
  logic             push_c;
  logic             pop_c;
  logic             wr_slot_c;
  logic [1:0]       occ_nxt_c;

  // Boundary detect, handshake, and queue bookkeeping
  always_comb begin
    boundary_c = (clk_cnt == CNT_LAST);
    push_c     = s_axis_tvalid && s_axis_tready;
    pop_c      = boundary_c && !pause && (occ != 2'd0);
    occ_nxt_c  = occ + 2'(push_c) - 2'(pop_c);
    // Slot for an incoming beat, after any same-edge pop has shifted the queue
    wr_slot_c  = ((occ - 2'(pop_c)) != 2'd0);
  end

  // Queue storage; the pop reads the pre-edge head, so there is no bypass
  always_ff @(posedge clk) begin
    if (pop_c) begin
      q0 <= q1;
    end
    if (push_c) begin
      if (wr_slot_c) begin
        q1 <= s_axis_tdata;
      end else begin
        q0 <= s_axis_tdata;
      end
    end
  end

  // Phase counter, occupancy, ready and frame register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt       <= '0;
      din           <= IDLE_FRAME;
      occ           <= 2'd0;
      s_axis_tready <= 1'b0;
    end else begin
      clk_cnt       <= boundary_c ? '0 : clk_cnt + CNT_WIDTH'(1);
      occ           <= occ_nxt_c;
      s_axis_tready <= (occ_nxt_c != 2'd2);
      if (boundary_c) begin
        din <= pop_c ? {2'b01, q0} : IDLE_FRAME;
      end
    end
  end

`ifdef TX_FRAME_SRC_STATS_EN
  // Frame-type counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_frame_cnt <= 32'd0;
      idle_frame_cnt <= 32'd0;
    end else if (boundary_c) begin
      if (pop_c) begin
        data_frame_cnt <= data_frame_cnt + 32'd1;
      end else begin
        idle_frame_cnt <= idle_frame_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tx_frame_src.sv
// Testbench for tx_frame_src (defaults, RATIO=4). A reference model tracks
// the frame phase and a scoreboard queue of pushed beats; each beat is
// popped at the boundary where it should be loaded. clk_cnt, din and
// s_axis_tready are compared every cycle, 1 time unit after the rising edge.
module tb_tx_frame_src;

  localparam int unsigned DW   = 256;
  localparam int unsigned PW   = DW - 2;
  localparam int unsigned RAT  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          pause;
  logic [1:0]    clk_cnt;
  logic [DW-1:0] din;
`ifdef TX_FRAME_SRC_STATS_EN
  logic [31:0]   data_frame_cnt;
  logic [31:0]   idle_frame_cnt;
`endif

  tx_frame_src dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .pause         (pause),
    .clk_cnt       (clk_cnt),
    .din           (din)
`ifdef TX_FRAME_SRC_STATS_EN
    ,
    .data_frame_cnt(data_frame_cnt),
    .idle_frame_cnt(idle_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] idle_f;
  logic [PW-1:0] exp_q[$];
  logic [DW-1:0] exp_din;
  int            m_cnt;
  bit            m_rdy;
  bit            last_push;
  int unsigned   m_dcnt;
  int unsigned   m_icnt;
  int            total = 0;
  int            bad   = 0;
  int            pushed;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Advance the model across one rising edge, then compare DUT outputs
  task automatic step();
    bit            boundary;
    bit            do_pop;
    bit            do_push;
    logic [PW-1:0] head;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt     = 0;
      exp_din   = idle_f;
      m_rdy     = 1'b0;
      m_dcnt    = 0;
      m_icnt    = 0;
      last_push = 1'b0;
    end else begin
      boundary = (m_cnt == RAT - 1);
      do_pop   = boundary && !pause && (exp_q.size() > 0);
      do_push  = tvalid && m_rdy;
      if (boundary) begin
        if (do_pop) begin
          head    = exp_q.pop_front();
          exp_din = {2'b01, head};
          m_dcnt++;
        end else begin
          exp_din = idle_f;
          m_icnt++;
        end
      end
      if (do_push) exp_q.push_back(tdata);
      m_rdy     = (exp_q.size() < 2);
      m_cnt     = (m_cnt + 1) % RAT;
      last_push = do_push;
    end
    @(posedge clk);
    #1;
    check("clk_cnt", DW'(clk_cnt), DW'(m_cnt));
    check("din", din, exp_din);
    check("tready", DW'(tready), DW'(m_rdy));
`ifdef TX_FRAME_SRC_STATS_EN
    check("data_frame_cnt", DW'(data_frame_cnt), DW'(m_dcnt));
    check("idle_frame_cnt", DW'(idle_frame_cnt), DW'(m_icnt));
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model phase equals ph (at most RAT steps)
  task automatic align(input int ph);
    for (int i = 0; i < RAT && m_cnt != ph; i++) step();
  endtask

  initial begin
    idle_f  = {2'b10, 8'h1E, 246'b0};
    rst_n   = 1'b0;
    tvalid  = 1'b0;
    pause   = 1'b0;
    tdata   = '0;
    m_cnt   = 0;
    exp_din = idle_f;
    m_rdy   = 1'b0;
    m_dcnt  = 0;
    m_icnt  = 0;

    // Reset state
    steps(2);
    check("reset_din_idle", din, idle_f);

    // Idle after reset release: counter runs, din stays IDLE
    rst_n = 1'b1;
    steps(9);

    // Single beat pushed as clk_cnt goes 0->1
    align(0);
    tdata  = PW'(254'hABCD);
    tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    steps(10);

    // Six back-to-back beats with tvalid held high
    pushed = 0;
    tvalid = 1'b1;
    tdata  = PW'(254'h1000);
    for (int i = 0; i < 200 && pushed < 6; i++) begin
      step();
      if (last_push) begin
        pushed++;
        tdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom};
      end
    end
    tvalid = 1'b0;
    steps(30);

    // Pause held at the boundary: IDLE loaded, beat retained
    align(1);
    tdata  = PW'(254'h5A5A);
    tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    align(3);
    pause = 1'b1;
    step();
    pause = 1'b0;
    steps(8);

    // Pause pulsed only at clk_cnt=1: no effect
    align(0);
    tdata  = PW'(254'h7777);
    tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    pause  = 1'b1;
    step();
    pause = 1'b0;
    steps(8);

    // Two beats queued, reset at clk_cnt=2 flushes them
    align(0);
    tvalid = 1'b1;
    tdata  = PW'(254'h1111);
    step();
    tdata  = PW'(254'h2222);
    step();
    tvalid = 1'b0;
    rst_n  = 1'b0;
    step();
    check("midreset_cnt", DW'(clk_cnt), DW'(0));
    check("midreset_din", din, idle_f);
    rst_n = 1'b1;
    steps(12);

    // Fresh reset, three beats, then run out the window
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tdata = PW'(254'hC000 + 254'(i));
      for (int k = 0; k < 20; k++) begin
        step();
        if (last_push) break;
      end
    end
    tvalid = 1'b0;
    steps(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
